// File: rtl/mem_slot_sched.sv
// mem_slot_sched: memory slot timebase for the shared SDRAM.
// Sequences the power-up wait and the initial refresh burst, then hands out
// fixed-length slots to refresh and six requesters. Every output is a flop.
module mem_slot_sched #(
  parameter int SLOT_LEN     = 8,
  parameter int REF_INTERVAL = 1560,
  parameter int PUP_CYCLES   = 20000,
  parameter int INIT_REF     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] gnt_sel,
  output logic       ref_cycle,
  output logic       slot_stp_adv,
  output logic       slot_stp,
  output logic       busy,
  output logic       pup_time,
  output logic       ref_ovf
);

  localparam int CW = (SLOT_LEN > 1)     ? $clog2(SLOT_LEN)     : 1;
  localparam int RW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int PW = (PUP_CYCLES > 1)   ? $clog2(PUP_CYCLES)   : 1;
  localparam int IW = (INIT_REF > 1)     ? $clog2(INIT_REF)     : 1;

  localparam logic [2:0] SEL_NONE = 3'd7;
  localparam logic [2:0] RR_FIRST = 3'd3;

  typedef enum logic [1:0] {PUP, INIT, IDLE, SLOT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] ref_cnt;
  logic [PW-1:0] pup_cnt;
  logic [IW-1:0] init_cnt;
  logic          ref_pend;
  logic [2:0]    rr_ptr;

  // Next round-robin candidate among requesters 3..5, wrapping 5 -> 3.
  function automatic logic [2:0] rr_inc(input logic [2:0] p);
    return (p == 3'd5) ? RR_FIRST : p + 3'd1;
  endfunction

  logic [2:0] rr_c1, rr_c2;
  logic       win_any, win_ref, rr_hit;
  logic [2:0] win_sel;
  logic       arb_now, ref_take, advancing;

  assign rr_c1 = rr_inc(rr_ptr);
  assign rr_c2 = rr_inc(rr_c1);

  // Arbitration points: every idle clock, and the last clock of a running slot.
  assign arb_now   = (state == IDLE) || (state == SLOT && slot_stp);
  assign ref_take  = arb_now && ref_pend;
  // The slot counter moves on inside a slot except on its final clock.
  assign advancing = (state == INIT || state == SLOT) && !slot_stp;

  // Fixed-priority winner: refresh, req[0..2], then round-robin over req[3..5].
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    win_any = 1'b1;
    win_ref = ref_pend;
    win_sel = SEL_NONE;
    rr_hit  = 1'b0;
    if (!ref_pend) begin
      if (req[0])            win_sel = 3'd0;
      else if (req[1])       win_sel = 3'd1;
      else if (req[2])       win_sel = 3'd2;
      else if (req[rr_ptr]) begin win_sel = rr_ptr; rr_hit = 1'b1; end
      else if (req[rr_c1])  begin win_sel = rr_c1;  rr_hit = 1'b1; end
      else if (req[rr_c2])  begin win_sel = rr_c2;  rr_hit = 1'b1; end
      else                   win_any = 1'b0;
    end
  end

  // Sequencer, slot counter, strobes, grants and refresh bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // this block sees the pre-edge values of the others.
    if (rst) begin
      state        <= PUP;
      cnt          <= '0;
      ref_cnt      <= '0;
      pup_cnt      <= '0;
      init_cnt     <= '0;
      ref_pend     <= 1'b0;
      rr_ptr       <= RR_FIRST;
      gnt          <= '0;
      gnt_sel      <= SEL_NONE;
      ref_cycle    <= 1'b0;
      slot_stp_adv <= 1'b0;
      slot_stp     <= 1'b0;
      busy         <= 1'b0;
      pup_time     <= 1'b1;
      ref_ovf      <= 1'b0;
    end else begin
      // Strobes look one clock ahead so they line up with the new cnt value.
      slot_stp_adv <= advancing && (cnt == CW'(SLOT_LEN - 3));
      slot_stp     <= advancing && (cnt == CW'(SLOT_LEN - 2));
      ref_ovf      <= 1'b0;

      case (state)
        PUP: begin
          if (pup_cnt == PW'(PUP_CYCLES - 1)) begin
            state     <= INIT;
            pup_time  <= 1'b0;
            ref_cycle <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            init_cnt  <= '0;
          end else begin
            pup_cnt <= pup_cnt + 1'b1;
          end
        end

        INIT: begin
          if (slot_stp) begin
            cnt <= '0;
            if (init_cnt == IW'(INIT_REF - 1)) begin
              state     <= IDLE;
              ref_cycle <= 1'b0;
              busy      <= 1'b0;
            end else begin
              init_cnt <= init_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          if (arb_now) begin
            cnt <= '0;
            if (win_any) begin
              state     <= SLOT;
              busy      <= 1'b1;
              ref_cycle <= win_ref;
              gnt_sel   <= win_sel;
              gnt       <= win_ref ? 6'b0 : (6'b000001 << win_sel);
              if (rr_hit) rr_ptr <= rr_inc(win_sel);
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              ref_cycle <= 1'b0;
              gnt_sel   <= SEL_NONE;
              gnt       <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // Refresh timebase runs only once the initial refresh burst is done.
      if (ref_take) ref_pend <= 1'b0;
      if (state == IDLE || state == SLOT) begin
        if (ref_cnt == RW'(REF_INTERVAL - 1)) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
          // A refresh being serviced on this very edge is not lost.
          ref_ovf  <= ref_pend && !ref_take;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_slot_sched.sv
// Self-checking bench for mem_slot_sched: directed scenarios and random
// requests, compared every clock against a behavioural slot model.
module tb_mem_slot_sched;

  localparam int L  = 4;
  localparam int RI = 40;
  localparam int PC = 10;
  localparam int IR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic [5:0] gnt;
  logic [2:0] gnt_sel;
  logic       ref_cycle, slot_stp_adv, slot_stp, busy, pup_time, ref_ovf;

  always #5 clk = ~clk;

  mem_slot_sched #(
    .SLOT_LEN(L), .REF_INTERVAL(RI), .PUP_CYCLES(PC), .INIT_REF(IR)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_sel(gnt_sel),
    .ref_cycle(ref_cycle), .slot_stp_adv(slot_stp_adv), .slot_stp(slot_stp),
    .busy(busy), .pup_time(pup_time), .ref_ovf(ref_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 power-up, 1 init refresh, 2 running.
  // m_pos is the clock index inside the current slot (-1 = no slot),
  // m_owner is the slot owner (0..5 requester, 6 refresh, -1 none).
  int m_phase, m_pup, m_init, m_pos, m_owner, m_age, m_rr;
  bit m_pend, m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decide the winner from the rules: refresh, 0, 1, 2, then rotate over 3..5.
  function automatic int pick(input logic [5:0] r);
    if (m_pend) return 6;
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = 3 + ((m_rr - 3 + i) % 3);
      if (r[k]) begin
        m_rr = (k == 5) ? 3 : k + 1;
        return k;
      end
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [5:0] r, input logic rs);
    bit pend;
    int w;
    m_ovf = 1'b0;
    if (rs) begin
      m_phase = 0; m_pup = 0; m_init = 0; m_pos = -1; m_owner = -1;
      m_age = 0; m_pend = 1'b0; m_rr = 3;
      return;
    end
    case (m_phase)
      0: begin
        if (m_pup == PC - 1) begin
          m_phase = 1; m_init = 0; m_pos = 0; m_owner = 6;
        end else m_pup++;
      end
      1: begin
        if (m_pos == L - 1) begin
          m_init++;
          if (m_init == IR) begin
            m_phase = 2; m_pos = -1; m_owner = -1; m_age = 0;
          end else m_pos = 0;
        end else m_pos++;
      end
      default: begin
        pend = m_pend;
        if (m_pos == -1 || m_pos == L - 1) begin
          w = pick(r);
          if (w < 0) begin
            m_pos = -1; m_owner = -1;
          end else begin
            m_pos = 0; m_owner = w;
            if (w == 6) pend = 1'b0;
          end
        end else m_pos++;
        m_age++;
        if (m_age % RI == 0) begin
          m_ovf = pend;
          pend  = 1'b1;
        end
        m_pend = pend;
      end
    endcase
  endfunction

  task automatic compare_all();
    logic [5:0] e_gnt;
    logic [2:0] e_sel;
    e_gnt = '0;
    e_sel = 3'd7;
    if (m_owner >= 0 && m_owner < 6) begin
      e_gnt[m_owner] = 1'b1;
      e_sel = 3'(m_owner);
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("gnt_sel", 32'(gnt_sel), 32'(e_sel));
    check("flags{ref,adv,stp,busy,pup,ovf}",
          32'({ref_cycle, slot_stp_adv, slot_stp, busy, pup_time, ref_ovf}),
          32'({m_owner == 6, m_pos == L - 2, m_pos == L - 1, m_pos >= 0,
               m_phase == 0, m_ovf}));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic [5:0] r, input logic rs);
    req = r;
    rst = rs;
    model_step(r, rs);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int pups, refs, ovfs, stps;
    int exp_rr[6];
    logic [2:0] got[$];

    // Reset and power-up: 10 clocks of pup_time, then 2 refresh slots of 4.
    cyc(6'b0, 1'b1);
    check("reset_gnt_sel", 32'(gnt_sel), 32'd7);
    pups = pup_time ? 1 : 0;
    for (int i = 0; i < 50 && pup_time; i++) begin
      cyc(6'b0, 1'b0);
      if (pup_time) pups++;
    end
    check("pup_clocks", 32'(pups), 32'(PC));
    refs = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      if (ref_cycle) refs++;
      cyc(6'b0, 1'b0);
    end
    check("init_ref_clocks", 32'(refs), 32'(IR * L));
    check("idle_gnt", 32'(gnt), 32'd0);

    // Single-clock request from requester 1.
    cyc(6'b000010, 1'b0);
    check("single_gnt", 32'(gnt), 32'h02);
    cyc(6'b0, 1'b0);
    cyc(6'b0, 1'b0);
    check("single_adv_3rd", 32'(slot_stp_adv), 32'd1);
    cyc(6'b0, 1'b0);
    check("single_stp_4th", 32'(slot_stp), 32'd1);
    cyc(6'b0, 1'b0);
    check("single_idle_after", 32'(busy), 32'd0);

    // Round robin over requesters 3..5 held continuously.
    exp_rr = '{3, 4, 5, 3, 4, 5};
    for (int i = 0; i < 80 && got.size() < 6; i++) begin
      cyc(6'b111000, 1'b0);
      if (m_pos == 0 && m_owner >= 0 && m_owner < 6) got.push_back(gnt_sel);
    end
    check("rr_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) check("rr_order", 32'(got[i]), 32'(exp_rr[i]));
    for (int i = 0; i < L + 1; i++) cyc(6'b0, 1'b0);

    // All requesting: requester 0 always wins, refresh still gets in.
    refs = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(6'b111111, 1'b0);
      check("all_req_sel", 32'(gnt_sel == 3'd0 || gnt_sel == 3'd7), 32'd1);
      if (m_pos == 0 && ref_cycle) refs++;
    end
    check("all_req_refresh_seen", 32'(refs >= 2), 32'd1);

    // Requester 0 held for 100 clocks: refresh never overflows.
    ovfs = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(6'b000001, 1'b0);
      if (ref_ovf) ovfs++;
    end
    check("no_ref_ovf", 32'(ovfs), 32'd0);

    // Reset on the second clock of a granted slot.
    for (int i = 0; i < 20 && !(m_owner == 0 && m_pos == 1); i++) cyc(6'b000001, 1'b0);
    check("abort_setup", 32'(m_owner == 0 && m_pos == 1), 32'd1);
    cyc(6'b000001, 1'b1);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pup", 32'(pup_time), 32'd1);
    stps = 0;
    pups = 1;
    for (int i = 0; i < 50 && pup_time; i++) begin
      cyc(6'b000001, 1'b0);
      if (slot_stp) stps++;
      if (pup_time) pups++;
    end
    check("abort_no_stp", 32'(stps), 32'd0);
    check("abort_pup_clocks", 32'(pups), 32'(PC));

    // Random traffic with rare resets.
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] r;
      r = 6'($urandom) & 6'($urandom);
      cyc(r, ($urandom_range(0, 399) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_slot_sched.md
# mem_slot_sched

Slot scheduler for the shared 32-bit SDRAM behind `mem_if_pv2_4`. It owns the memory slot timebase and sequences SDRAM power-up and refresh. It arbitrates six video/M4 requesters onto fixed-length memory slots, issuing one-hot grants plus the `slot_stp_adv`/`slot_stp` strobes that the video input, video process and M4 paths key their memory cycles on. It sits between those requesters and the memory interface, replacing free-running cycle generation.

## Interface
Parameters:
- `SLOT_LEN`, 8: clocks per memory slot, ≥3.
- `REF_INTERVAL`, 1560: clocks between refresh requests.
- `PUP_CYCLES`, 20000: power-up wait in clocks.
- `INIT_REF`, 8: refresh slots issued after power-up.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  6  level requests:
  - [0] out_vid_rd
  - [1] in_vid_wr
  - [2] out_vid_wr
  - [3] in_vid_rd
  - [4] m4_cmd_wr
  - [5] m4_cmd_rd
- `gnt`  out  6  one-hot grant, held for the whole slot.
- `gnt_sel`  out  3  index of the granted requester. 7 means no requester slot.
- `ref_cycle`  out  1  current slot is a refresh slot.
- `slot_stp_adv`  out  1  pulse, second-to-last clock of a slot.
- `slot_stp`  out  1  pulse, last clock of a slot.
- `busy`  out  1  a slot (requester or refresh) is active.
- `pup_time`  out  1  high during the power-up wait.
- `ref_ovf`  out  1  one-clock pulse when a refresh is requested while the previous one is still pending.

## Operation
- States:
  - PUP: wait `PUP_CYCLES` clocks with `pup_time`=1 and no slots.
  - INIT: issue `INIT_REF` back-to-back refresh slots; `req` is ignored.
  - IDLE: no slot active.
  - SLOT: a requester or refresh slot is active.
- Transitions:
  - PUP→INIT when the wait count reaches `PUP_CYCLES`-1.
  - INIT→IDLE after the last init refresh slot's `slot_stp`.
  - IDLE→SLOT when `ref_pend` or any `req` bit is set.
  - SLOT→SLOT at `slot_stp` if there is a winner.
  - SLOT→IDLE at `slot_stp` if there is no winner.
- Slot counter `cnt` runs 0..`SLOT_LEN`-1 within a slot.
  - `slot_stp_adv` = (`cnt`==`SLOT_LEN`-2).
  - `slot_stp` = (`cnt`==`SLOT_LEN`-1).
- Arbitration is evaluated in IDLE every clock and in SLOT on the `slot_stp` clock. Priority:
  1. `ref_pend`
  2. `req[0]`
  3. `req[1]`
  4. `req[2]`
  5. round-robin among `req[3..5]`, starting at `rr_ptr`.
- `rr_ptr` resets to 3. After a round-robin grant to k, `rr_ptr` = k+1, wrapping 5→3. It is unchanged by any other grant.
- Requester protocol:
  - A requester holding `gnt` must drop `req` by its own `slot_stp` clock if it has no further work.
  - If `req` is still high at that clock, the requester is re-arbitrated normally (back-to-back slots allowed).
- Refresh:
  - `ref_cnt` free-runs 0..`REF_INTERVAL`-1 from the first IDLE entry after INIT.
  - At wrap, `ref_pend` is set.
  - If `ref_pend` is already 1 at wrap, `ref_ovf` pulses; the pending refresh is still only one.
  - `ref_pend` clears at the edge its refresh slot starts.
  - Refresh slot outputs: `gnt`=0, `gnt_sel`=7, `ref_cycle`=1.

## Timing
- Reset values (the edge where `rst`=1 is sampled):
  - `gnt`=0, `gnt_sel`=7, `ref_cycle`=0
  - `slot_stp_adv`=0, `slot_stp`=0, `busy`=0, `ref_ovf`=0
  - `pup_time`=1, state=PUP
  - `cnt`=0, `ref_cnt`=0, `ref_pend`=0, `rr_ptr`=3
- Reset mid-slot aborts the slot and restarts PUP on the next edge.
- All outputs are registered.
- IDLE latency: `req` high at edge t → `gnt`, `busy` and `cnt`=0 valid from edge t+1.
- Back-to-back slots: the new `gnt` is valid at the edge after `slot_stp`, with zero idle clocks between slots.
- `gnt`, `gnt_sel` and `ref_cycle` are stable for exactly `SLOT_LEN` clocks.
- A `req` bit that drops mid-slot does not shorten the slot.
- Simultaneous `ref_cnt` wrap and arbitration: the newly set `ref_pend` is not seen until the following arbitration.

## Test plan
Bench parameters: `SLOT_LEN`=4, `PUP_CYCLES`=10, `INIT_REF`=2, `REF_INTERVAL`=40.
- Reset, no requests:
  - `pup_time` high for 10 clocks.
  - Then 2 refresh slots of 4 clocks each (`ref_cycle`=1, `busy`=1).
  - Then IDLE with `gnt`=0 and `gnt_sel`=7.
- IDLE, then `req`=6'b000010 for one clock → `gnt`=6'b000010 from the next edge for 4 clocks.
  - `slot_stp_adv` and `slot_stp` fall on the 3rd and 4th clocks of the slot.
  - IDLE afterwards.
- `req`=6'b111000 held continuously → grant order 3,4,5,3,4,5 in consecutive slots with no gaps.
- `req`=6'b111111 held → `req[0]` wins every slot.
  - A refresh slot is inserted within one slot of each `ref_cnt` wrap.
  - Refresh preempts `req[0]` at that arbitration.
- Hold `req[0]` continuously for 100 clocks → `ref_ovf` never pulses.
  - Force `ref_pend` unserviceable in a separate run by asserting `rst` mid-test; the run must restart from PUP.
- Assert `rst` on the 2nd clock of a granted slot → next edge: `gnt`=0, `busy`=0, `pup_time`=1, `slot_stp` never fires for the aborted slot.
